// File: rtl/mpadd_sequencer.sv
// mpadd_sequencer: streams WIDTH-bit chunks of two WIDTH*NCHUNK-bit operands, LSB first, through an external adder.
// Optional MPADD_SUB_EN adds an iSub port so the sequencer can compute A-B.
`default_nettype none

module mpadd_sequencer #(
  parameter int WIDTH  = 32,
  parameter int NCHUNK = 8
) (
  input  logic                     iClk,
  input  logic                     iRst_n,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic [WIDTH*NCHUNK-1:0]  iOpA,
  input  logic [WIDTH*NCHUNK-1:0]  iOpB,
  input  logic                     iCin,
`ifdef MPADD_SUB_EN
  input  logic                     iSub,
`endif
  output logic                     oValid,
  input  logic                     iReady,
  output logic [WIDTH*NCHUNK-1:0]  oSum,
  output logic                     oCout,
  output logic [WIDTH-1:0]         oAddA,
  output logic [WIDTH-1:0]         oAddB,
  output logic                     oAddC,
  input  logic [WIDTH-1:0]         iAddS,
  input  logic                     iAddC
);

  localparam int W    = WIDTH * NCHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              sub_q;
  logic [WIDTH-1:0]  a_chunk;
  logic [WIDTH-1:0]  b_chunk;
  logic              init_carry;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDXW'(k)) begin
        a_chunk = op_a[k*WIDTH +: WIDTH];
        b_chunk = op_b[k*WIDTH +: WIDTH];
      end
    end
  end

  // Subtraction is A + ~B + 1, so the inversion happens on the way to the adder.
  assign oAddA  = (state == RUN) ? a_chunk : '0;
  assign oAddB  = (state == RUN) ? (b_chunk ^ {WIDTH{sub_q}}) : '0;
  assign oAddC  = (state == RUN) ? carry : 1'b0;
  assign oReady = (state == IDLE);
  assign oValid = (state == DONE);

`ifdef MPADD_SUB_EN
  assign init_carry = iSub | iCin;
`else
  assign init_carry = iCin;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      sub_q <= 1'b0;
      oSum  <= '0;
      oCout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iValid) begin
            op_a  <= iOpA;
            op_b  <= iOpB;
            carry <= init_carry;
`ifdef MPADD_SUB_EN
            sub_q <= iSub;
`else
            sub_q <= 1'b0;
`endif
            idx   <= '0;
            oSum  <= '0;
            oCout <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (idx == IDXW'(k)) oSum[k*WIDTH +: WIDTH] <= iAddS;
          end
          carry <= iAddC;
          if (idx == IDXW'(NCHUNK - 1)) begin
            oCout <= iAddC;
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (iReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
